// File: rtl/mnist_pkg.sv
// rtl/mnist_pkg.sv - shared bus geometry, streamer FSM states and label decode
package mnist_pkg;

   localparam int IMG_BITS   = 784;
   localparam int LABEL_BITS = 10;
   localparam int BUS_W      = IMG_BITS + LABEL_BITS;
   localparam int PIX_LSB    = LABEL_BITS;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_PRESENT,
      S_DONE
   } streamer_state_t;

   // Labels outside 0..9 decode to no class bit at all.
   function automatic logic [LABEL_BITS-1:0] label_to_onehot(input logic [3:0] label);
      logic [LABEL_BITS-1:0] oh;
      oh = '0;
      if (label < 4'd10) begin
         oh = LABEL_BITS'(1) << label;
      end
      return oh;
   endfunction

endpackage

// File: rtl/mnist_word_assembler.sv
// rtl/mnist_word_assembler.sv - scatters returned memory words into the pixel register and decodes the label word
module mnist_word_assembler
   import mnist_pkg::*;
#(
   parameter int WORD_W = 16,
   parameter int IDX_W  = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  word_vld,
   input  logic [IDX_W-1:0]      word_idx,
   input  logic [WORD_W-1:0]     word_data,
   output logic [IMG_BITS-1:0]   pixels,
   output logic [LABEL_BITS-1:0] label_onehot,
   output logic                  label_last
);

   localparam int PIX_WORDS = IMG_BITS / WORD_W;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pixels <= '0;
      end else if (word_vld && (word_idx < IDX_W'(PIX_WORDS))) begin
         pixels[WORD_W*word_idx +: WORD_W] <= word_data;
      end
   end

   // The label word is the final word of a sample; it is consumed straight off the bus.
   assign label_last   = word_vld && (word_idx == IDX_W'(PIX_WORDS));
   assign label_onehot = label_to_onehot(word_data[3:0]);

endmodule

// File: rtl/mnist_sample_streamer.sv
// rtl/mnist_sample_streamer.sv - fetches packed MNIST samples and streams them as 794-bit image_data
// Optional MNIST_STREAMER_LABEL_CHECK_EN: skip samples with label > 9 and flag label_err.
module mnist_sample_streamer
   import mnist_pkg::*;
#(
   parameter int NUM_SAMPLES = 1000,
   parameter int NUM_EPOCHS  = 4,
   parameter int WORD_W      = 16,
   parameter int ADDR_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [WORD_W-1:0] mem_rd_data,
   output logic [BUS_W-1:0]  image_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [15:0]       sample_idx,
   output logic [7:0]        epoch_idx,
   output logic              busy,
   output logic              done
`ifdef MNIST_STREAMER_LABEL_CHECK_EN
   ,
   output logic              label_err
`endif
);

   localparam int                WPS       = IMG_BITS / WORD_W + 1;
   localparam int                IDX_W     = $clog2(WPS + 1);
   localparam logic [ADDR_W-1:0] WPS_A     = ADDR_W'(WPS);
   localparam logic [IDX_W-1:0]  LAST_WORD = IDX_W'(WPS - 1);

   streamer_state_t       state;
   logic [ADDR_W-1:0]     base;
   logic [IDX_W-1:0]      cur_word;
   logic [IDX_W-1:0]      rd_idx;
   logic                  rd_vld;
   logic [IMG_BITS-1:0]   pixels;
   logic [LABEL_BITS-1:0] label_onehot;
   logic                  label_last;
   logic                  skip;
   logic                  advance;
   logic                  last_sample;
   logic                  last_epoch;

   mnist_word_assembler #(
      .WORD_W(WORD_W),
      .IDX_W (IDX_W)
   ) u_assembler (
      .clk         (clk),
      .rst_n       (rst_n),
      .word_vld    (rd_vld),
      .word_idx    (rd_idx),
      .word_data   (mem_rd_data),
      .pixels      (pixels),
      .label_onehot(label_onehot),
      .label_last  (label_last)
   );

`ifdef MNIST_STREAMER_LABEL_CHECK_EN
   assign skip = label_last && (state == S_FETCH) && (label_onehot == '0);
`else
   assign skip = 1'b0;
`endif

   assign advance     = ((state == S_PRESENT) && out_ready) || skip;
   assign last_sample = (sample_idx == 16'(NUM_SAMPLES - 1));
   assign last_epoch  = (epoch_idx == 8'(NUM_EPOCHS - 1));

   // Read data returns one cycle after the strobe; reset drops anything in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_vld <= 1'b0;
         rd_idx <= '0;
      end else begin
         rd_vld <= mem_rd_en;
         rd_idx <= cur_word;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         mem_rd_en  <= 1'b0;
         mem_addr   <= '0;
         base       <= '0;
         cur_word   <= '0;
         image_data <= '0;
         out_valid  <= 1'b0;
         sample_idx <= '0;
         epoch_idx  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
`ifdef MNIST_STREAMER_LABEL_CHECK_EN
         label_err  <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state      <= S_FETCH;
                  busy       <= 1'b1;
                  sample_idx <= '0;
                  epoch_idx  <= '0;
                  base       <= '0;
                  mem_addr   <= '0;
                  cur_word   <= '0;
                  mem_rd_en  <= 1'b1;
`ifdef MNIST_STREAMER_LABEL_CHECK_EN
                  label_err  <= 1'b0;
`endif
               end
            end
            S_FETCH: begin
               if (mem_rd_en) begin
                  if (cur_word == LAST_WORD) begin
                     mem_rd_en <= 1'b0;
                  end else begin
                     mem_addr <= mem_addr + 1'b1;
                     cur_word <= cur_word + 1'b1;
                  end
               end
               if (label_last && !skip) begin
                  image_data <= {pixels, label_onehot};
                  out_valid  <= 1'b1;
                  state      <= S_PRESENT;
               end
`ifdef MNIST_STREAMER_LABEL_CHECK_EN
               if (skip) begin
                  label_err <= 1'b1;
               end
`endif
            end
            S_PRESENT: begin
            end
            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase

         // Shared by an accepted sample and a skipped one.
         if (advance) begin
            out_valid <= 1'b0;
            cur_word  <= '0;
            if (!last_sample) begin
               sample_idx <= sample_idx + 16'd1;
               base       <= base + WPS_A;
               mem_addr   <= base + WPS_A;
               mem_rd_en  <= 1'b1;
               state      <= S_FETCH;
            end else if (!last_epoch) begin
               epoch_idx  <= epoch_idx + 8'd1;
               sample_idx <= '0;
               base       <= '0;
               mem_addr   <= '0;
               mem_rd_en  <= 1'b1;
               state      <= S_FETCH;
            end else begin
               state <= S_DONE;
               done  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mnist_sample_streamer.sv
// tb/tb_mnist_sample_streamer.sv - directed self-checking bench for mnist_sample_streamer
module tb_mnist_sample_streamer;
   import mnist_pkg::*;

   localparam int NS        = 3;
   localparam int NE        = 2;
   localparam int WPS       = 50;
   localparam int MEM_WORDS = NS * WPS;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              out_ready = 1'b0;
   logic              mem_rd_en;
   logic [15:0]       mem_addr;
   logic [15:0]       mem_rd_data = '0;
   logic [BUS_W-1:0]  image_data;
   logic              out_valid;
   logic [15:0]       sample_idx;
   logic [7:0]        epoch_idx;
   logic              busy;
   logic              done;
`ifdef MNIST_STREAMER_LABEL_CHECK_EN
   logic              label_err;
`endif

   logic [15:0] mem [0:MEM_WORDS-1];

   int n_cmp = 0;
   int n_bad = 0;

   logic [BUS_W-1:0] acc_img[$];
   int acc_s[$], acc_e[$], acc_cyc[$];
   int post_s[$], post_e[$], post_a[$], post_rd[$];
   int addr_log[$];
   int done_n, done_cyc, clash, timed_out;

   mnist_sample_streamer #(
      .NUM_SAMPLES(NS),
      .NUM_EPOCHS (NE),
      .WORD_W     (16),
      .ADDR_W     (16)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .mem_rd_en  (mem_rd_en),
      .mem_addr   (mem_addr),
      .mem_rd_data(mem_rd_data),
      .image_data (image_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .sample_idx (sample_idx),
      .epoch_idx  (epoch_idx),
      .busy       (busy),
      .done       (done)
`ifdef MNIST_STREAMER_LABEL_CHECK_EN
      ,
      .label_err  (label_err)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_rd_en) begin
         mem_rd_data <= (int'(mem_addr) < MEM_WORDS) ? mem[mem_addr] : 16'hDEAD;
      end
   end

   // Sample 0: all-ones pixels, label 6; sample 1: zero pixels, label 3; sample 2: pattern, label2.
   task automatic fill_mem(input int label2);
      for (int k = 0; k < WPS - 1; k++) begin
         mem[k]         = 16'hFFFF;
         mem[WPS + k]   = 16'h0000;
         mem[2*WPS + k] = 16'(k * 257) ^ 16'h5A3C;
      end
      mem[WPS - 1]   = 16'h1236;
      mem[2*WPS - 1] = 16'hFFF3;
      mem[3*WPS - 1] = 16'h0000 | 16'(label2);
   endtask

   function automatic logic [BUS_W-1:0] exp_img(input int s);
      logic [BUS_W-1:0] img;
      logic [15:0]      lw;
      img = '0;
      for (int k = 0; k < WPS - 1; k++) begin
         img[10 + 16*k +: 16] = mem[s*WPS + k];
      end
      lw = mem[s*WPS + WPS - 1];
      if (lw[3:0] <= 4'd9) img[9:0] = 10'd1 << lw[3:0];
      return img;
   endfunction

   task automatic apply_reset();
      rst_n = 1'b0;
      start = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic run_collect(input int start_glitch);
      bit prev_acc;
      acc_img.delete(); acc_s.delete(); acc_e.delete(); acc_cyc.delete();
      post_s.delete(); post_e.delete(); post_a.delete(); post_rd.delete();
      addr_log.delete();
      done_n = 0; done_cyc = 0; clash = 0; prev_acc = 0;
      @(negedge clk);
      start = 1'b1;
      out_ready = 1'b1;
      for (int cyc = 1; cyc <= 1000; cyc++) begin
         @(negedge clk);
         start = (start_glitch != 0) && (cyc % start_glitch == 0);
         if (prev_acc) begin
            post_s.push_back(int'(sample_idx));
            post_e.push_back(int'(epoch_idx));
            post_a.push_back(int'(mem_addr));
            post_rd.push_back(int'(mem_rd_en));
         end
         prev_acc = out_valid && out_ready;
         if (mem_rd_en) addr_log.push_back(int'(mem_addr));
         if (mem_rd_en && out_valid) clash++;
         if (out_valid && out_ready) begin
            acc_img.push_back(image_data);
            acc_s.push_back(int'(sample_idx));
            acc_e.push_back(int'(epoch_idx));
            acc_cyc.push_back(cyc);
         end
         if (done) begin
            done_n++;
            done_cyc = cyc;
         end
         if (done_n > 0 && cyc >= done_cyc + 3) break;
      end
      start = 1'b0;
      timed_out = (done_n == 0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({mem_rd_en, out_valid, busy, done} !== 4'b0) begin
         n_bad++;
         $display("FAIL reset_flags: got %b expected 0000", {mem_rd_en, out_valid, busy, done});
      end
      n_cmp++;
      if (mem_addr !== 16'd0 || sample_idx !== 16'd0 || epoch_idx !== 8'd0) begin
         n_bad++;
         $display("FAIL reset_counters: addr %0d sample %0d epoch %0d expected 0", mem_addr, sample_idx, epoch_idx);
      end
      n_cmp++;
      if (image_data !== {BUS_W{1'b0}}) begin
         n_bad++;
         $display("FAIL reset_image: label bits %h, expected all zero bus", image_data[9:0]);
      end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || mem_rd_en !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_idle: busy %b rd_en %b expected 0 0", busy, mem_rd_en);
      end
   endtask

   task automatic test_basic();
      fill_mem(9);
      run_collect(0);
      n_cmp++;
      if (timed_out != 0) begin
         n_bad++;
         $display("FAIL basic_timeout: no done within budget, got %0d expected 0", timed_out);
      end
      n_cmp++;
      if (acc_img.size() != NS*NE) begin
         n_bad++;
         $display("FAIL basic_accepts: got %0d expected %0d", acc_img.size(), NS*NE);
      end
      if (acc_img.size() >= 2) begin
         n_cmp++;
         if (acc_img[0][BUS_W-1:10] !== {IMG_BITS{1'b1}} || acc_img[0][9:0] !== 10'h040) begin
            n_bad++;
            $display("FAIL basic_sample0: label %h expected 040 with all-ones pixels", acc_img[0][9:0]);
         end
         n_cmp++;
         if (acc_img[1][BUS_W-1:10] !== {IMG_BITS{1'b0}} || acc_img[1][9:0] !== 10'h008) begin
            n_bad++;
            $display("FAIL basic_sample1: label %h expected 008 with zero pixels", acc_img[1][9:0]);
         end
      end
      for (int i = 0; i < acc_img.size() && i < NS*NE; i++) begin
         n_cmp++;
         if (acc_img[i] !== exp_img(i % NS) || acc_s[i] != i % NS || acc_e[i] != i / NS) begin
            n_bad++;
            $display("FAIL basic_accept%0d: label %h sample %0d epoch %0d expected label %h sample %0d epoch %0d",
                     i, acc_img[i][9:0], acc_s[i], acc_e[i], exp_img(i % NS) & 10'h3FF, i % NS, i / NS);
         end
      end
      n_cmp++;
      if (done_n != 1) begin
         n_bad++;
         $display("FAIL basic_done_count: got %0d expected 1", done_n);
      end
      n_cmp++;
      if (addr_log.size() != NE*MEM_WORDS) begin
         n_bad++;
         $display("FAIL basic_read_count: got %0d expected %0d", addr_log.size(), NE*MEM_WORDS);
      end
      for (int i = 0; i < addr_log.size() && i < NE*MEM_WORDS; i++) begin
         n_cmp++;
         if (addr_log[i] != i % MEM_WORDS) begin
            n_bad++;
            $display("FAIL basic_addr%0d: got %0d expected %0d", i, addr_log[i], i % MEM_WORDS);
         end
      end
      n_cmp++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || image_data !== exp_img(2)) begin
         n_bad++;
         $display("FAIL basic_end_state: busy %b valid %b label %h expected 0 0 with last sample retained",
                  busy, out_valid, image_data[9:0]);
      end
   endtask

   task automatic test_back_to_back();
      fill_mem(9);
      run_collect(0);
      n_cmp++;
      if (acc_cyc.size() != NS*NE || clash != 0) begin
         n_bad++;
         $display("FAIL b2b_setup: accepts %0d read-while-valid %0d expected %0d 0", acc_cyc.size(), clash, NS*NE);
      end
      if (acc_cyc.size() > 0) begin
         n_cmp++;
         if (acc_cyc[0] != WPS + 2) begin
            n_bad++;
            $display("FAIL b2b_first_latency: got %0d expected %0d", acc_cyc[0], WPS + 2);
         end
         for (int i = 1; i < acc_cyc.size(); i++) begin
            n_cmp++;
            if (acc_cyc[i] - acc_cyc[i-1] != WPS + 2) begin
               n_bad++;
               $display("FAIL b2b_spacing%0d: got %0d expected %0d", i, acc_cyc[i] - acc_cyc[i-1], WPS + 2);
            end
         end
         n_cmp++;
         if (done_cyc != acc_cyc[acc_cyc.size()-1] + 1) begin
            n_bad++;
            $display("FAIL b2b_done_cycle: got %0d expected %0d", done_cyc, acc_cyc[acc_cyc.size()-1] + 1);
         end
      end
   endtask

   task automatic test_epoch_wrap();
      fill_mem(9);
      run_collect(0);
      n_cmp++;
      if (post_s.size() < NS*NE) begin
         n_bad++;
         $display("FAIL wrap_post_count: got %0d expected %0d", post_s.size(), NS*NE);
      end else begin
         n_cmp++;
         if (post_s[0] != 1 || post_a[0] != 50 || post_a[1] != 100) begin
            n_bad++;
            $display("FAIL wrap_advance: sample %0d addr %0d addr %0d expected 1 50 100", post_s[0], post_a[0], post_a[1]);
         end
         n_cmp++;
         if (post_e[2] != 1 || post_s[2] != 0 || post_a[2] != 0 || post_rd[2] != 1) begin
            n_bad++;
            $display("FAIL wrap_epoch: epoch %0d sample %0d addr %0d rd_en %0d expected 1 0 0 1",
                     post_e[2], post_s[2], post_a[2], post_rd[2]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [BUS_W-1:0] snap;
      logic [15:0]      snap_s;
      bit               got;
      int               unstable, rd_seen;
      fill_mem(9);
      @(negedge clk);
      start = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      got = 0;
      for (int i = 0; i < 200; i++) begin
         if (out_valid) begin
            got = 1;
            break;
         end
         @(negedge clk);
      end
      n_cmp++;
      if (!got) begin
         n_bad++;
         $display("FAIL bp_valid_timeout: out_valid %b expected 1", out_valid);
      end
      snap = image_data;
      snap_s = sample_idx;
      unstable = 0;
      rd_seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (image_data !== snap || sample_idx !== snap_s || out_valid !== 1'b1) unstable++;
         if (mem_rd_en !== 1'b0) rd_seen++;
      end
      n_cmp++;
      if (unstable != 0 || rd_seen != 0) begin
         n_bad++;
         $display("FAIL bp_stable: unstable cycles %0d read cycles %0d expected 0 0", unstable, rd_seen);
      end
      n_cmp++;
      if (snap !== exp_img(0)) begin
         n_bad++;
         $display("FAIL bp_image: label %h expected 040", snap[9:0]);
      end
      out_ready = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0 || mem_rd_en !== 1'b1 || mem_addr !== 16'd50 || sample_idx !== 16'd1) begin
         n_bad++;
         $display("FAIL bp_accept: valid %b rd_en %b addr %0d sample %0d expected 0 1 50 1",
                  out_valid, mem_rd_en, mem_addr, sample_idx);
      end
      apply_reset();
   endtask

   task automatic test_reset_mid_fetch();
      bit found;
      fill_mem(9);
      @(negedge clk);
      start = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      found = 0;
      for (int i = 0; i < 100; i++) begin
         if (mem_rd_en && mem_addr == 16'd20) begin
            found = 1;
            break;
         end
         @(negedge clk);
      end
      n_cmp++;
      if (!found) begin
         n_bad++;
         $display("FAIL midrst_reach_word20: addr %0d expected 20", mem_addr);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({mem_rd_en, out_valid, busy, done} !== 4'b0 || mem_addr !== 16'd0 ||
          sample_idx !== 16'd0 || epoch_idx !== 8'd0 || image_data !== {BUS_W{1'b0}}) begin
         n_bad++;
         $display("FAIL midrst_outputs: flags %b addr %0d sample %0d epoch %0d expected all zero",
                  {mem_rd_en, out_valid, busy, done}, mem_addr, sample_idx, epoch_idx);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (mem_rd_en !== 1'b0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL midrst_idle: rd_en %b busy %b expected 0 0", mem_rd_en, busy);
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_cmp++;
      if (mem_rd_en !== 1'b1 || mem_addr !== 16'd0 || busy !== 1'b1) begin
         n_bad++;
         $display("FAIL midrst_restart: rd_en %b addr %0d busy %b expected 1 0 1", mem_rd_en, mem_addr, busy);
      end
      found = 0;
      for (int i = 0; i < 200; i++) begin
         if (out_valid) begin
            found = 1;
            break;
         end
         @(negedge clk);
      end
      n_cmp++;
      if (!found || image_data !== exp_img(0) || sample_idx !== 16'd0) begin
         n_bad++;
         $display("FAIL midrst_refetch: valid %b label %h sample %0d expected 1 040 0",
                  out_valid, image_data[9:0], sample_idx);
      end
      apply_reset();
   endtask

   task automatic test_label12();
      fill_mem(12);
      run_collect(0);
      n_cmp++;
      if (done_n != 1) begin
         n_bad++;
         $display("FAIL lbl12_done: got %0d expected 1", done_n);
      end
`ifdef MNIST_STREAMER_LABEL_CHECK_EN
      n_cmp++;
      if (acc_s.size() != 4) begin
         n_bad++;
         $display("FAIL lbl12_skip_count: got %0d expected 4", acc_s.size());
      end else begin
         n_cmp++;
         if (acc_s[0] != 0 || acc_s[1] != 1 || acc_s[2] != 0 || acc_s[3] != 1 || acc_e[2] != 1) begin
            n_bad++;
            $display("FAIL lbl12_skip_order: got %0d %0d %0d %0d expected 0 1 0 1",
                     acc_s[0], acc_s[1], acc_s[2], acc_s[3]);
         end
      end
      n_cmp++;
      if (label_err !== 1'b1) begin
         n_bad++;
         $display("FAIL lbl12_label_err: got %b expected 1", label_err);
      end
`else
      n_cmp++;
      if (acc_img.size() != NS*NE) begin
         n_bad++;
         $display("FAIL lbl12_present_count: got %0d expected %0d", acc_img.size(), NS*NE);
      end else begin
         n_cmp++;
         if (acc_img[2][9:0] !== 10'h000 || acc_img[5] !== exp_img(2) || acc_s[2] != 2) begin
            n_bad++;
            $display("FAIL lbl12_present: label %h sample %0d expected 000 2", acc_img[2][9:0], acc_s[2]);
         end
      end
`endif
   endtask

   task automatic test_start_busy();
      fill_mem(9);
      run_collect(17);
      n_cmp++;
      if (acc_s.size() != NS*NE || done_n != 1 || addr_log.size() != NE*MEM_WORDS) begin
         n_bad++;
         $display("FAIL busy_start_counts: accepts %0d done %0d reads %0d expected %0d 1 %0d",
                  acc_s.size(), done_n, addr_log.size(), NS*NE, NE*MEM_WORDS);
      end
      for (int i = 0; i < acc_s.size() && i < NS*NE; i++) begin
         n_cmp++;
         if (acc_s[i] != i % NS || acc_e[i] != i / NS || acc_cyc[i] != (i + 1) * (WPS + 2)) begin
            n_bad++;
            $display("FAIL busy_start_accept%0d: sample %0d epoch %0d cycle %0d expected %0d %0d %0d",
                     i, acc_s[i], acc_e[i], acc_cyc[i], i % NS, i / NS, (i + 1) * (WPS + 2));
         end
      end
      for (int i = 0; i < addr_log.size() && i < NE*MEM_WORDS; i++) begin
         n_cmp++;
         if (addr_log[i] != i % MEM_WORDS) begin
            n_bad++;
            $display("FAIL busy_start_addr%0d: got %0d expected %0d", i, addr_log[i], i % MEM_WORDS);
         end
      end
`ifdef MNIST_STREAMER_LABEL_CHECK_EN
      n_cmp++;
      if (label_err !== 1'b0) begin
         n_bad++;
         $display("FAIL busy_start_label_err_clear: got %b expected 0", label_err);
      end
`endif
   endtask

   initial begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] = '0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_epoch_wrap();
      test_backpressure();
      test_reset_mid_fetch();
      test_label12();
      test_start_busy();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mnist_sample_streamer.md
Name: mnist_sample_streamer

Overview:
- Producer side of the 794-bit `image_data` training bus that feeds the ten per-class pseudo-linear learners.
- Reads packed MNIST samples from a synchronous sample memory and assembles each sample into the bus layout: pixel bitvector plus one-hot label.
- Presents each sample with a valid/ready handshake and sequences samples and epochs. One learner update happens per accepted sample.

Parameters:
- NUM_SAMPLES, 1000, samples per epoch (≥1).
- NUM_EPOCHS, 4, epochs per run (≥1).
- WORD_W, 16, memory data width; must divide 784.
- ADDR_W, 16, memory address width; must satisfy NUM_SAMPLES*(784/WORD_W+1) ≤ 2^ADDR_W.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- start  in  1  one-cycle pulse; begins a run from sample 0, epoch 0
- mem_rd_en  out  1  memory read strobe
- mem_addr  out  ADDR_W  memory word address
- mem_rd_data  in  WORD_W  read data, valid exactly 1 cycle after mem_rd_en
- image_data  out  794  [793:10] pixels, [9:0] one-hot label
- out_valid  out  1  image_data holds a complete sample
- out_ready  in  1  consumer accepts the sample
- sample_idx  out  16  index of the current sample within the epoch
- epoch_idx  out  8  current epoch
- busy  out  1  run in progress
- done  out  1  one-cycle pulse after the last sample of the last epoch is accepted

Behaviour:
- Reset: rst_n is asynchronous and active-low; clock is clk.
  - On reset, all outputs are 0 and the FSM enters IDLE.
  - Reset mid-run abandons the run. Any memory read in flight is discarded.
- Memory layout: each sample occupies WPS = 784/WORD_W + 1 consecutive words.
  - Words 0..WPS-2 are pixels. Word k maps to image_data[10+WORD_W*k +: WORD_W].
  - Word WPS-1 carries the label in bits [3:0]; upper bits are ignored.
  - Base address starts at 0 each epoch and advances by WPS per sample. Use an adder-based running base; no multiplier.
- Label encoding: image_data[9:0] = 1 << label. Bit 6 is therefore the class-6 target.
- FSM:
  - IDLE: busy=0. On start go to FETCH with sample_idx=0, epoch_idx=0, base=0.
  - FETCH: issue one read per cycle for words 0..WPS-1 (mem_addr = base+word). Capture each returned word 1 cycle later into the assembly register.
    - Minimum duration: WPS+1 cycles from entering FETCH to out_valid=1.
    - image_data is not updated while out_valid=1. The assembly register is separate from the output register, and the output register is loaded in one cycle at the end of FETCH.
  - PRESENT: out_valid=1; image_data, sample_idx and epoch_idx are stable until accepted.
    - Acceptance occurs on a cycle with out_valid && out_ready. out_valid drops the next cycle.
    - After acceptance: if sample_idx < NUM_SAMPLES-1, increment sample_idx and base, then go to FETCH.
    - Otherwise, at the end of an epoch: if epoch_idx < NUM_EPOCHS-1, increment epoch_idx, clear sample_idx and base, then go to FETCH.
    - Otherwise go to DONE.
  - DONE: pulse done for 1 cycle, then go to IDLE. image_data retains the last sample.
- start is ignored while busy=1.
- out_ready held high gives back-to-back operation at one sample per WPS+2 cycles.
- mem_rd_en is never asserted outside FETCH.

Optional Feature:
- Macro: MNIST_STREAMER_LABEL_CHECK_EN.
- Defined:
  - A label word with value > 9 causes the sample to be skipped. It is never presented; index and base advance as if it had been accepted.
  - A sticky `label_err` output port (1 bit) is added. It is cleared on start.
  - If the skipped sample is the last of the run, done still pulses.
- Undefined:
  - There is no label_err port.
  - Labels > 9 produce image_data[9:0] = 0 (no class bit set) and the sample is presented normally.

Decomposition:
- Shared package mnist_pkg holds:
  - IMG_BITS=784, LABEL_BITS=10, BUS_W=794, PIX_LSB=10.
  - Streamer FSM state enum.
  - A label_to_onehot function.
- One natural sub-module: mnist_word_assembler. It takes the word index and data-valid strobe, writes the WORD_W slice into the 794-bit assembly register, and decodes the label word.

Test Plan:
1. Basic run: NUM_SAMPLES=2, NUM_EPOCHS=1, WORD_W=16, out_ready=1. Memory has sample 0 pixel words 0xFFFF with label 6, and sample 1 pixel words 0x0000 with label 3.
   - Sample 0 appears with image_data[793:10] all-ones and [9:0]=0x040.
   - Sample 1 appears with pixels zero and [9:0]=0x008.
   - done pulses once; addresses run 0..99.
2. Backpressure: out_ready=0 for 20 cycles while out_valid=1.
   - image_data, sample_idx and out_valid are stable throughout, and mem_rd_en stays 0.
   - Acceptance occurs on the first cycle out_ready=1.
3. Epoch wrap: NUM_SAMPLES=3, NUM_EPOCHS=2.
   - After the 3rd acceptance, epoch_idx=1, sample_idx=0 and mem_addr restarts at 0.
   - done follows the 6th acceptance.
4. Reset mid-FETCH at word 20.
   - All outputs read 0 and the FSM is in IDLE.
   - A new start refetches sample 0 from address 0.
5. Label 12, with and without MNIST_STREAMER_LABEL_CHECK_EN.
   - With the macro, the sample is skipped and label_err=1.
   - Without the macro, the sample is presented with [9:0]=0.
6. start pulsed while busy=1: no effect on sample_idx, epoch_idx or mem_addr sequence.
